// File: rtl/sigma_dec_key_feeder.sv
// Decryption-side sigma stage: stores NK round keys, replays them
// in reverse order and XORs each onto one state beat.
module sigma_dec_key_feeder #(
   parameter int ROUNDS = 12,
   parameter int W      = 128
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clear,
   input  logic         key_wr_en,
   input  logic [W-1:0] key_wr_data,
   output logic         keys_ready,
   input  logic         start,
   output logic         busy,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   output logic         in_ready,
   output logic         out_valid,
   output logic [W-1:0] out_data,
   input  logic         out_ready,
   output logic [3:0]   out_round,
   output logic         out_last
);

   localparam logic [3:0] LAST = 4'(ROUNDS);

   typedef enum logic [1:0] {
      LOAD,
      IDLE,
      RUN
   } state_t;

   state_t       state;
   logic [3:0]   wr_ptr;
   logic [3:0]   rd_ptr;
   logic [W-1:0] keys [ROUNDS+1];
   logic         key_we;
   logic         accept;

   // One-entry output register: refill in the same cycle it drains
   assign in_ready = (state == RUN) && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;
   assign key_we   = (state == LOAD) && key_wr_en && !clear;

   always_ff @(posedge clk) begin
      if (key_we)
         keys[wr_ptr] <= key_wr_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= LOAD;
         wr_ptr     <= '0;
         rd_ptr     <= LAST;
         keys_ready <= 1'b0;
         busy       <= 1'b0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_round  <= '0;
         out_last   <= 1'b0;
      end else if (clear) begin
         state      <= LOAD;
         wr_ptr     <= '0;
         rd_ptr     <= LAST;
         keys_ready <= 1'b0;
         busy       <= 1'b0;
         out_valid  <= 1'b0;
      end else begin
         if (out_valid && out_ready)
            out_valid <= 1'b0;
         unique case (state)
            LOAD: begin
               if (key_wr_en) begin
                  wr_ptr <= wr_ptr + 4'd1;
                  if (wr_ptr == LAST) begin
                     state      <= IDLE;
                     keys_ready <= 1'b1;
                  end
               end
            end
            IDLE: begin
               if (start) begin
                  state  <= RUN;
                  rd_ptr <= LAST;
                  busy   <= 1'b1;
               end
            end
            RUN: begin
               if (accept) begin
                  out_data  <= in_data ^ keys[rd_ptr];
                  out_round <= rd_ptr;
                  out_last  <= (rd_ptr == 4'd0);
                  out_valid <= 1'b1;
                  // Key 0 is the final whitening: the pass ends here
                  if (rd_ptr == 4'd0) begin
                     state  <= IDLE;
                     busy   <= 1'b0;
                     rd_ptr <= LAST;
                  end else begin
                     rd_ptr <= rd_ptr - 4'd1;
                  end
               end
            end
            default: state <= LOAD;
         endcase
      end
   end

endmodule

// File: tb/tb_sigma_dec_key_feeder.sv
// Randomized bench for sigma_dec_key_feeder against a queue-based
// model of the reverse key replay.
module tb_sigma_dec_key_feeder;

   localparam int ROUNDS = 12;
   localparam int NK     = ROUNDS + 1;
   localparam int W      = 128;

   logic         clk = 1'b0;
   logic         rst;
   logic         clear;
   logic         key_wr_en;
   logic [W-1:0] key_wr_data;
   logic         keys_ready;
   logic         start;
   logic         busy;
   logic         in_valid;
   logic [W-1:0] in_data;
   logic         in_ready;
   logic         out_valid;
   logic [W-1:0] out_data;
   logic         out_ready;
   logic [3:0]   out_round;
   logic         out_last;

   sigma_dec_key_feeder #(.ROUNDS(ROUNDS), .W(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .clear      (clear),
      .key_wr_en  (key_wr_en),
      .key_wr_data(key_wr_data),
      .keys_ready (keys_ready),
      .start      (start),
      .busy       (busy),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_ready  (out_ready),
      .out_round  (out_round),
      .out_last   (out_last)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [W-1:0] d;
      logic [3:0]   r;
      logic         l;
   } res_t;

   int           checks = 0;
   int           errors = 0;
   logic [W-1:0] kref     [NK];
   logic [W-1:0] pass_in  [NK];
   logic [W-1:0] pass_out [NK];
   logic [W-1:0] orig     [NK];
   res_t         q [$];
   int           ptr, bi, oi, wi;
   bit           running;

   function automatic logic [W-1:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic model_reset();
      q.delete();
      running = 0;
      ptr = ROUNDS;
      wi = 0;
      bi = 0;
      oi = 0;
   endtask

   task automatic rand_inputs();
      for (int i = 0; i < NK; i++) pass_in[i] = rnd128();
   endtask

   task automatic check_zero(input string tag);
      checks++;
      if ({keys_ready, busy, in_ready, out_valid, out_last} !== 5'b0) begin
         errors++;
         $display("FAIL %s flags got kr%b b%b ir%b ov%b ol%b exp all 0",
                  tag, keys_ready, busy, in_ready, out_valid, out_last);
      end
      checks++;
      if (out_data !== '0 || out_round !== 4'd0) begin
         errors++;
         $display("FAIL %s data got %h round %0d exp 0", tag, out_data, out_round);
      end
   endtask

   // One clock of handshake traffic, checked against the model
   task automatic step(input logic iv, input logic orr);
      logic exp_ir, acc, take;
      res_t h, got;
      in_valid  = iv;
      in_data   = (bi < NK) ? pass_in[bi] : rnd128();
      out_ready = orr;
      #1;
      exp_ir = running && (q.size() == 0 || orr);
      checks++;
      if (in_ready !== exp_ir) begin
         errors++;
         $display("FAIL in_ready got %b exp %b", in_ready, exp_ir);
      end
      checks++;
      if (out_valid !== (q.size() != 0)) begin
         errors++;
         $display("FAIL out_valid got %b exp %b", out_valid, q.size() != 0);
      end
      checks++;
      if (busy !== running) begin
         errors++;
         $display("FAIL busy got %b exp %b", busy, running);
      end
      take = 1'b0;
      if (q.size() != 0) begin
         h   = q[0];
         got = '{out_data, out_round, out_last};
         checks++;
         if (got !== h) begin
            errors++;
            $display("FAIL result got %h r%0d l%b exp %h r%0d l%b",
                     got.d, got.r, got.l, h.d, h.r, h.l);
         end
         take = orr;
         if (take && oi < NK) pass_out[oi] = out_data;
      end
      acc = iv && exp_ir;
      @(posedge clk);
      #1;
      if (take) begin
         void'(q.pop_front());
         oi++;
      end
      if (acc) begin
         q.push_back('{in_data ^ kref[ptr], 4'(ptr), ptr == 0});
         bi++;
         if (ptr == 0) running = 0;
         else ptr--;
      end
   endtask

   task automatic run_pass(input int vp, input int rp);
      int n = 0;
      while ((running || q.size() != 0) && n < 800) begin
         step($urandom_range(99) < vp, $urandom_range(99) < rp);
         n++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      checks++;
      if (running || q.size() != 0) begin
         errors++;
         $display("FAIL pass_timeout beats %0d results %0d exp %0d", bi, oi, NK);
      end
   endtask

   task automatic load_keys(input int n, input bit pat);
      for (int i = 0; i < n; i++) begin
         key_wr_en   = 1'b1;
         key_wr_data = pat ? {16{8'(wi)}} : rnd128();
         if (wi < NK) kref[wi] = key_wr_data;
         wi++;
         @(posedge clk);
         #1;
         key_wr_en = 1'b0;
         checks++;
         if (keys_ready !== (wi >= NK)) begin
            errors++;
            $display("FAIL keys_ready after write %0d got %b exp %b",
                     wi, keys_ready, wi >= NK);
         end
      end
   endtask

   task automatic start_pass();
      start = 1'b1;
      @(posedge clk);
      #1;
      start   = 1'b0;
      running = 1;
      ptr = ROUNDS;
      bi = 0;
      oi = 0;
      checks++;
      if (busy !== 1'b1 || keys_ready !== 1'b1) begin
         errors++;
         $display("FAIL start busy %b keys_ready %b exp 1 1", busy, keys_ready);
      end
   endtask

   task automatic do_clear();
      clear = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
      model_reset();
      checks++;
      if ({keys_ready, busy, out_valid, in_ready} !== 4'b0) begin
         errors++;
         $display("FAIL clear kr%b b%b ov%b ir%b exp 0000",
                  keys_ready, busy, out_valid, in_ready);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      clear = 0; key_wr_en = 0; start = 0; in_valid = 0; out_ready = 0;
      key_wr_data = '0;
      in_data = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_zero("reset");
      rst = 1'b0;
      @(posedge clk);
      #1;
      check_zero("after_reset");
   endtask

   task automatic test_order();
      load_keys(NK, 1'b1);
      start_pass();
      for (int i = 0; i < NK; i++) pass_in[i] = '0;
      run_pass(100, 100);
      for (int j = 0; j < NK; j++) begin
         checks++;
         if (pass_out[j] !== {16{8'(ROUNDS - j)}}) begin
            errors++;
            $display("FAIL order beat %0d got %h exp %h",
                     j, pass_out[j], {16{8'(ROUNDS - j)}});
         end
      end
   endtask

   task automatic test_involution();
      do_clear();
      load_keys(NK, 1'b0);
      rand_inputs();
      pass_in[0] = 128'h0123456789ABCDEF0123456789ABCDEF;
      orig = pass_in;
      start_pass();
      run_pass(70, 70);
      pass_in = pass_out;
      start_pass();
      run_pass(70, 70);
      for (int j = 0; j < NK; j++) begin
         checks++;
         if (pass_out[j] !== orig[j]) begin
            errors++;
            $display("FAIL involution beat %0d got %h exp %h", j, pass_out[j], orig[j]);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [W-1:0] first;
      rand_inputs();
      start_pass();
      step(1'b1, 1'b0);
      first = out_data;
      repeat (5) begin
         step(1'b1, 1'b0);
         checks++;
         if (out_data !== first) begin
            errors++;
            $display("FAIL hold_data got %h exp %h", out_data, first);
         end
      end
      run_pass(100, 100);
      checks++;
      if (bi != NK || oi != NK) begin
         errors++;
         $display("FAIL backpressure_count beats %0d results %0d exp %0d", bi, oi, NK);
      end
   endtask

   task automatic test_early_start();
      do_clear();
      load_keys(10, 1'b0);
      start = 1'b1;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      checks++;
      if (busy !== 1'b0 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL early_start busy %b in_ready %b exp 0 0", busy, in_ready);
      end
      in_valid = 1'b0;
      load_keys(2, 1'b0);
      start = 1'b1;
      load_keys(1, 1'b0);
      start = 1'b0;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL start_on_last_key busy got %b exp 0", busy);
      end
      rand_inputs();
      start_pass();
      run_pass(80, 60);
   endtask

   task automatic test_clear();
      rand_inputs();
      start_pass();
      repeat (6) step(1'b1, 1'b1);
      clear = 1'b1;
      start = 1'b1;
      in_valid = 1'b1;
      key_wr_en = 1'b1;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      clear = 0; start = 0; in_valid = 0; key_wr_en = 0;
      model_reset();
      checks++;
      if ({out_valid, busy, keys_ready, in_ready} !== 4'b0) begin
         errors++;
         $display("FAIL mid_clear ov%b b%b kr%b ir%b exp 0000",
                  out_valid, busy, keys_ready, in_ready);
      end
      load_keys(NK, 1'b0);
      rand_inputs();
      start_pass();
      run_pass(100, 100);
      checks++;
      if (pass_out[0] !== (pass_in[0] ^ kref[ROUNDS])) begin
         errors++;
         $display("FAIL clear_first got %h exp %h", pass_out[0], pass_in[0] ^ kref[ROUNDS]);
      end
   endtask

   task automatic test_async_reset();
      rand_inputs();
      start_pass();
      repeat (4) step(1'b1, 1'b1);
      in_valid = 1'b0;
      #3;
      rst = 1'b1;
      #1;
      check_zero("async_reset");
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      load_keys(NK, 1'b0);
      load_keys(1, 1'b0);
      rand_inputs();
      start_pass();
      run_pass(90, 90);
   endtask

   task automatic test_back_to_back();
      repeat (4) begin
         rand_inputs();
         start_pass();
         run_pass($urandom_range(30, 100), $urandom_range(30, 100));
      end
      rand_inputs();
      start_pass();
      run_pass(100, 100);
   endtask

   initial begin
      test_reset();
      test_order();
      test_involution();
      test_backpressure();
      test_early_start();
      test_clear();
      test_async_reset();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
